shiftsub_div: RTL and testbench

//   Iterative restoring shift-subtract divider, one quotient bit per clock.

---
 rtl/shiftsub_div_pkg.sv | 11 +
 rtl/shiftsub_div_if.sv | 23 ++
 rtl/shiftsub_div_step.sv | 22 ++
 rtl/shiftsub_div.sv | 130 +++++++++++++
 tb/tb_shiftsub_div.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/shiftsub_div_pkg.sv
// Shared types and sizing helpers for the shift-subtract divider.
package shiftsub_div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  // Step counter width: enough bits to count 0..bw-1.
  function automatic int cnt_w(input int bw);
    return (bw > 1) ? $clog2(bw) : 1;
  endfunction

endpackage

// File: rtl/shiftsub_div_if.sv
// Start/done operand bus of the divider; master = requester, slave = divider.
interface shiftsub_div_if #(
  parameter int BW = 4
);
  logic          inval;
  logic [BW-1:0] inA;
  logic [BW-1:0] inB;
  logic [BW-1:0] quot;
  logic [BW-1:0] rem;
  logic          outval;
  logic          divStarted;
  logic          divzero;

  modport master (
    output inval, inA, inB,
    input  quot, rem, outval, divStarted, divzero
  );

  modport slave (
    input  inval, inA, inB,
    output quot, rem, outval, divStarted, divzero
  );
endinterface

// File: rtl/shiftsub_div_step.sv
// One combinational restoring-division step: shift in a bit, trial-subtract.
module shiftsub_div_step #(
  parameter int BW = 4
) (
  input  logic [BW:0]   r,
  input  logic          in_bit,
  input  logic [BW-1:0] divisor,
  output logic [BW:0]   r_nxt,
  output logic          qbit
);

  logic [BW:0] shifted;
  logic [BW:0] trial;

  assign shifted = {r[BW-1:0], in_bit};
  assign trial   = shifted - {1'b0, divisor};

  // r[BW] set would mean the shifted value already exceeds any divisor.
  assign qbit  = r[BW] | ~trial[BW];
  assign r_nxt = qbit ? trial : shifted;

endmodule

// File: rtl/shiftsub_div.sv
// Iterative restoring divider, one quotient bit per clock, with divide-by-zero flag.
// Define SHIFTSUB_DIV_SIGNED_EN for two's-complement operands (truncating division).
module shiftsub_div
  import shiftsub_div_pkg::*;
#(
  parameter int BW = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  shiftsub_div_if.slave        bus,
  output div_state_t           dbg_state
);

  localparam int CW = cnt_w(BW);

  // Handshake: inval is taken on a rising edge while the FSM is idle (this
  // includes the outval cycle, so ops can run back to back); once accepted,
  // divStarted stays high through the single-cycle outval pulse, and inval
  // is ignored until then. quot/rem/divzero hold until the next result.

  div_state_t    state_q, state_nxt;
  logic          accept, step_en, commit, last_step;
  logic [CW-1:0] cnt_q;
  logic [BW-1:0] dvd_q, dvs_q, a_q;
  logic [BW:0]   r_q, r_nxt;
  logic          qbit, dz_q;
  logic [BW-1:0] a_mag, b_mag, quot_fin, rem_fin;
  logic [BW-1:0] quot_q, rem_q;
  logic          outval_q, busy_q, divzero_q;

  assign last_step = (cnt_q == CW'(BW - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:    if (bus.inval) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept  = (state_q == IDLE) && bus.inval;
    step_en = (state_q == RUN);
    commit  = (state_q == DONE);
  end

  shiftsub_div_step #(.BW(BW)) u_step (
    .r       (r_q),
    .in_bit  (dvd_q[BW-1]),
    .divisor (dvs_q),
    .r_nxt   (r_nxt),
    .qbit    (qbit)
  );

`ifdef SHIFTSUB_DIV_SIGNED_EN
  logic a_neg_q, q_neg_q;

  assign a_mag = bus.inA[BW-1] ? -bus.inA : bus.inA;
  assign b_mag = bus.inB[BW-1] ? -bus.inB : bus.inB;
  // Most-negative / -1 falls out naturally: magnitude 2^(BW-1) reads back as most-negative.
  assign quot_fin = dz_q ? '1  : (q_neg_q ? -dvd_q : dvd_q);
  assign rem_fin  = dz_q ? a_q : (a_neg_q ? -r_q[BW-1:0] : r_q[BW-1:0]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_neg_q <= 1'b0;
      q_neg_q <= 1'b0;
    end else if (accept) begin
      a_neg_q <= bus.inA[BW-1];
      q_neg_q <= bus.inA[BW-1] ^ bus.inB[BW-1];
    end
  end
`else
  assign a_mag    = bus.inA;
  assign b_mag    = bus.inB;
  assign quot_fin = dz_q ? '1  : dvd_q;
  assign rem_fin  = dz_q ? a_q : r_q[BW-1:0];
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      a_q       <= '0;
      r_q       <= '0;
      dz_q      <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      divzero_q <= 1'b0;
      outval_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      outval_q <= commit;
      busy_q   <= (state_q != IDLE) || accept;
      if (accept) begin
        dvd_q <= a_mag;
        dvs_q <= b_mag;
        a_q   <= bus.inA;
        r_q   <= '0;
        dz_q  <= (bus.inB == '0);
        cnt_q <= '0;
      end else if (step_en) begin
        r_q   <= r_nxt;
        dvd_q <= {dvd_q[BW-2:0], qbit};
        cnt_q <= last_step ? '0 : cnt_q + 1'b1;
      end
      if (commit) begin
        quot_q    <= quot_fin;
        rem_q     <= rem_fin;
        divzero_q <= dz_q;
      end
    end
  end

  assign bus.quot       = quot_q;
  assign bus.rem        = rem_q;
  assign bus.outval     = outval_q;
  assign bus.divStarted = busy_q;
  assign bus.divzero    = divzero_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_shiftsub_div.sv
// Directed bench for shiftsub_div (BW=4); vectors follow SHIFTSUB_DIV_SIGNED_EN.
module tb_shiftsub_div;
  import shiftsub_div_pkg::*;

  localparam int BW = 4;

  logic       clk = 1'b0;
  logic       rstn;
  div_state_t dbg_state;
  int         n_checks = 0;
  int         n_pass   = 0;

  shiftsub_div_if #(.BW(BW)) bus ();

  shiftsub_div #(.BW(BW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- drivers ----------------
  task automatic start_op(input logic [BW-1:0] a, input logic [BW-1:0] b);
    bus.inA   = a;
    bus.inB   = b;
    bus.inval = 1'b1;
    @(posedge clk);
    #1;
    bus.inval = 1'b0;
  endtask

  // Counts edges after the accepting edge until outval is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.outval) break;
    end
  endtask

  task automatic run_op(input string tag, input logic [BW-1:0] a, input logic [BW-1:0] b,
                        input logic [BW-1:0] eq, input logic [BW-1:0] er, input logic edz);
    int lat;
    start_op(a, b);
    check({tag, " outval_after_accept"}, 32'(bus.outval), 32'd0);
    check({tag, " busy_after_accept"}, 32'(bus.divStarted), 32'd1);
    wait_done(lat);
    check({tag, " latency"}, 32'(lat), 32'd5);
    check({tag, " quot"}, 32'(bus.quot), 32'(eq));
    check({tag, " rem"}, 32'(bus.rem), 32'(er));
    check({tag, " divzero"}, 32'(bus.divzero), 32'(edz));
    check({tag, " busy_in_done"}, 32'(bus.divStarted), 32'd1);
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk);
    #1;
    check({tag, " outval_idle"}, 32'(bus.outval), 32'd0);
    check({tag, " busy_idle"}, 32'(bus.divStarted), 32'd0);
  endtask

  task automatic quiet_cycles(input string tag, input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.outval) pulses++;
    end
    check({tag, " stray_outval"}, 32'(pulses), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    rstn      = 1'b0;
    bus.inval = 1'b0;
    bus.inA   = '0;
    bus.inB   = '0;
    #12;
    check("rst quot", 32'(bus.quot), 32'd0);
    check("rst rem", 32'(bus.rem), 32'd0);
    check("rst outval", 32'(bus.outval), 32'd0);
    check("rst busy", 32'(bus.divStarted), 32'd0);
    check("rst divzero", 32'(bus.divzero), 32'd0);
    check("rst state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

`ifdef SHIFTSUB_DIV_SIGNED_EN
    run_op("-7/2", 4'h9, 4'h2, 4'hD, 4'hF, 1'b0);
    idle_check("-7/2");
    run_op("-8/-1", 4'h8, 4'hF, 4'h8, 4'h0, 1'b0);
    run_op("-8/0", 4'h8, 4'h0, 4'hF, 4'h8, 1'b1);
    idle_check("-8/0");
    run_op("7/-2", 4'h7, 4'hE, 4'hD, 4'h1, 1'b0);
    run_op("-6/-4", 4'hA, 4'hC, 4'h1, 4'hE, 1'b0);
    idle_check("-6/-4");
`else
    run_op("13/3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    idle_check("13/3");
    run_op("7/9", 4'd7, 4'd9, 4'd0, 4'd7, 1'b0);
    run_op("15/15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0);
    idle_check("15/15");
    run_op("11/0", 4'd11, 4'd0, 4'hF, 4'hB, 1'b1);
    idle_check("11/0");
    run_op("15/1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    run_op("0/5", 4'd0, 4'd5, 4'd0, 4'd0, 1'b0);
    idle_check("0/5");
`endif

    // inval pulsed while busy must be ignored
    start_op(4'd6, 4'd4);
    bus.inA   = 4'd2;
    bus.inB   = 4'd1;
    bus.inval = 1'b1;
    @(posedge clk);
    #1;
    bus.inval = 1'b0;
    wait_done(lat);
    check("ign latency_rest", 32'(lat), 32'd4);
    check("ign quot", 32'(bus.quot), 32'd1);
    check("ign rem", 32'(bus.rem), 32'd2);
    quiet_cycles("ign", 8);
    check("ign busy_after", 32'(bus.divStarted), 32'd0);

    // asynchronous reset mid-RUN
    start_op(4'd5, 4'd3);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("arst quot", 32'(bus.quot), 32'd0);
    check("arst rem", 32'(bus.rem), 32'd0);
    check("arst outval", 32'(bus.outval), 32'd0);
    check("arst busy", 32'(bus.divStarted), 32'd0);
    check("arst divzero", 32'(bus.divzero), 32'd0);
    check("arst state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rstn = 1'b1;
    quiet_cycles("arst", 8);
`ifdef SHIFTSUB_DIV_SIGNED_EN
    run_op("7/2", 4'd7, 4'd2, 4'd3, 4'd1, 1'b0);
`else
    run_op("9/2", 4'd9, 4'd2, 4'd4, 4'd1, 1'b0);
`endif
    idle_check("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
